seq_mag_comp: RTL and testbench
===============================

// Module: seq_mag_comp
// PURPOSE
//  - Multi-cycle, parametrised magnitude comparator; successor to the fixed 4-bit cascaded comparator.
//  - Compares A and B one DIGIT-bit slice per clock, MSB slice first, with early exit on the first unequal slice.
//  - Keeps great/equal/less cascade inputs; they break ties when every slice is equal.
//  - start/busy/done handshake; registered L/EQ/G results for the counter/control datapath.
// PARAMETERS
//  WIDTH   16  operand width in bits; must be a multiple of DIGIT (elaboration error otherwise)
//  DIGIT   4   bits compared per cycle; DIGIT==WIDTH gives single-slice operation
//  (local) NDIG = WIDTH/DIGIT  number of slices
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      request; sampled only when ready (IDLE or DONE state)
//  a       in   WIDTH  operand A, captured on accepted start
//  b       in   WIDTH  operand B, captured on accepted start
//  great   in   1      cascade-in: lower stage says A>B
//  equal   in   1      cascade-in: lower stage says A==B
//  less    in   1      cascade-in: lower stage says A<B
//  busy    out  1      high while in RUN
//  done    out  1      one-cycle pulse; L/EQ/G valid from this cycle
//  L       out  1      result A<B, held until next accepted start
//  EQ      out  1      result A==B, held
//  G       out  1      result A>B, held
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; busy=0, done=0, L=0, EQ=0, G=0; operand/cascade regs cleared.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE --start--> RUN: capture a, b, great/equal/less; slice index idx=NDIG-1.
//    RUN: each cycle compare slice idx of A vs B (unsigned).
//      A slice > B slice -> G=1,L=0,EQ=0; go DONE.
//      A slice < B slice -> L=1,G=0,EQ=0; go DONE.
//      slices equal, idx>0 -> idx=idx-1; stay RUN.
//      slices equal, idx==0 -> cascade resolve; go DONE.
//    DONE: done=1 for exactly this cycle.
//      start=1 -> RUN with new capture (back-to-back accepted).
//      else -> IDLE.
//  - Cascade resolve, fixed priority great > less > equal:
//      great=1 -> G; else less=1 -> L; else EQ.
//      All-zero cascade -> EQ.
//  - Latency: start accepted at edge 0; k slices examined (1..NDIG) -> done high in cycle k+1.
//    Worst case NDIG+1 cycles; first-slice mismatch gives 2.
//  - Exactly one of L/EQ/G is high once done has pulsed; all three read 0 only after reset.
//  - start while busy (RUN) is ignored; a/b/cascade changes during RUN have no effect.
//  - L/EQ/G change only on the DONE-entry edge; they are not cleared by start.
//  - Mid-operation reset: RUN is abandoned immediately, no done pulse, outputs return to reset values.
// CONFIGURATION
//  COMP_SIGNED_EN defined:
//    - Adds input port sgn (1 bit), captured with start.
//    - sgn=1: two's-complement compare; MSB of the top slice is inverted in both operands before comparing.
//    - Cascade inputs are used unchanged.
//  COMP_SIGNED_EN undefined:
//    - sgn port absent; unsigned compare only.
// TESTING
//  1 Reset: assert rst mid-RUN (WIDTH=16, DIGIT=4) -> busy=0, done=0, L=EQ=G=0 same cycle; no later done.
//  2 Early exit: a=16'h9000, b=16'h1FFF -> G=1; done in cycle 2 after start.
//  3 Full scan: a=16'h1234, b=16'h1235 -> L=1; done in cycle 5 (NDIG+1).
//  4 Cascade: a=b=16'hBEEF with cascade great=1,less=1 -> G=1.
//       a=b=16'hBEEF with all cascade inputs 0 -> EQ=1.
//  5 Handshake: start held high through RUN and DONE -> second compare begins on DONE edge; RUN-time start ignored.
//       done pulses once per compare.
//  6 COMP_SIGNED_EN: sgn=1, a=16'hFFFF (-1), b=16'h0001 -> L=1; same with sgn=0 -> G=1.

Source files
------------

// File: rtl/seq_mag_comp_if.sv
// Handshake/operand bundle for seq_mag_comp.
// COMP_SIGNED_EN adds the sgn request bit.
interface seq_mag_comp_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             great;
  logic             equal;
  logic             less;
`ifdef COMP_SIGNED_EN
  logic             sgn;
`endif
  logic             busy;
  logic             done;
  logic             L;
  logic             EQ;
  logic             G;

`ifdef COMP_SIGNED_EN
  modport master (output start, a, b, great, equal, less, sgn,
                  input  busy, done, L, EQ, G);
  modport slave  (input  start, a, b, great, equal, less, sgn,
                  output busy, done, L, EQ, G);
`else
  modport master (output start, a, b, great, equal, less,
                  input  busy, done, L, EQ, G);
  modport slave  (input  start, a, b, great, equal, less,
                  output busy, done, L, EQ, G);
`endif
endinterface

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator, DIGIT bits per clock, MSB slice first, early exit.
// Optional two's-complement mode via COMP_SIGNED_EN.
module seq_mag_comp #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic          clk,
  input logic          rst,
  seq_mag_comp_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("seq_mag_comp: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       cas_q;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] flip;
  logic [DIGIT-1:0] a_sl;
  logic [DIGIT-1:0] b_sl;

  // Signed mode biases both operands by flipping the sign bit once at capture,
  // so the slice datapath stays purely unsigned.
  always_comb begin
    flip = '0;
`ifdef COMP_SIGNED_EN
    if (bus.sgn) flip[WIDTH-1] = 1'b1;
`endif
  end

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        a_sl = a_q[i*DIGIT +: DIGIT];
        b_sl = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cas_q    <= '0;
      idx      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.L    <= 1'b0;
      bus.EQ   <= 1'b0;
      bus.G    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_q      <= bus.a ^ flip;
            b_q      <= bus.b ^ flip;
            cas_q    <= {bus.great, bus.equal, bus.less};
            idx      <= IW'(NDIG - 1);
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if ((a_sl != b_sl) || (idx == '0)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            if (a_sl > b_sl) begin
              {bus.L, bus.EQ, bus.G} <= 3'b001;
            end else if (a_sl < b_sl) begin
              {bus.L, bus.EQ, bus.G} <= 3'b100;
            end else begin
              // All slices tied: cascade decides, great over less over equal.
              casez (cas_q)
                3'b1??:  {bus.L, bus.EQ, bus.G} <= 3'b001;
                3'b0?1:  {bus.L, bus.EQ, bus.G} <= 3'b100;
                default: {bus.L, bus.EQ, bus.G} <= 3'b010;
              endcase
            end
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed self-checking bench for seq_mag_comp (WIDTH=16, DIGIT=4).
module tb_seq_mag_comp;
  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_count  = 0;
  int   d0;

  always #5 clk = ~clk;

  seq_mag_comp_if #(.WIDTH(16)) bus ();

  seq_mag_comp #(.WIDTH(16), .DIGIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.done === 1'b1) done_count++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Launch one compare, then scramble inputs so a missed capture shows up.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic g, input logic e, input logic l);
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.great = g;
    bus.equal = e;
    bus.less  = l;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = ~bv;
    bus.great = ~g;
    bus.equal = ~e;
    bus.less  = ~l;
    checkOutput("busy_after_accept", {31'b0, bus.busy}, 32'd1);
  endtask

  task automatic waitResult(input string tag, input int exp_lat, input logic [2:0] exp_leg);
    int cyc = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput({tag, "_latency"}, cyc + 1, exp_lat);
    checkOutput({tag, "_leg"}, {29'b0, bus.L, bus.EQ, bus.G}, {29'b0, exp_leg});
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
    checkOutput({tag, "_held"}, {29'b0, bus.L, bus.EQ, bus.G}, {29'b0, exp_leg});
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.great = 1'b0;
    bus.equal = 1'b0;
    bus.less  = 1'b0;
`ifdef COMP_SIGNED_EN
    bus.sgn   = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("reset_done", {31'b0, bus.done}, 32'd0);
    checkOutput("reset_leg", {29'b0, bus.L, bus.EQ, bus.G}, 32'd0);
    rst = 1'b0;

    applyStimulus(16'h9000, 16'h1FFF, 1'b0, 1'b0, 1'b0);
    waitResult("early_exit", 2, 3'b001);

    applyStimulus(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0);
    waitResult("full_scan", 5, 3'b100);

    applyStimulus(16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 1'b1);
    waitResult("cascade_great", 5, 3'b001);
    applyStimulus(16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    waitResult("cascade_zero", 5, 3'b010);
    applyStimulus(16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 1'b1);
    waitResult("cascade_less", 5, 3'b100);
    applyStimulus(16'h0F00, 16'h0E00, 1'b0, 1'b0, 1'b1);
    waitResult("second_slice", 3, 3'b001);

    // Back-to-back: start held high from IDLE through RUN and DONE.
    d0 = done_count;
    @(negedge clk);
    bus.a     = 16'h9000;
    bus.b     = 16'h1FFF;
    bus.great = 1'b0;
    bus.equal = 1'b0;
    bus.less  = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 16'h0001;
    bus.b = 16'h0002;
    checkOutput("b2b_busy_first", {31'b0, bus.busy}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("b2b_first_done", {31'b0, bus.done}, 32'd1);
    checkOutput("b2b_first_leg", {29'b0, bus.L, bus.EQ, bus.G}, 32'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0000;
    checkOutput("b2b_busy_second", {31'b0, bus.busy}, 32'd1);
    checkOutput("b2b_not_cleared", {29'b0, bus.L, bus.EQ, bus.G}, 32'd1);
    waitResult("b2b_second", 5, 3'b100);
    checkOutput("b2b_done_pulses", done_count - d0, 32'd2);

    // Reset in the middle of a compare.
    applyStimulus(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    d0  = done_count;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("midrst_done", {31'b0, bus.done}, 32'd0);
    checkOutput("midrst_leg", {29'b0, bus.L, bus.EQ, bus.G}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midrst_no_done", done_count - d0, 32'd0);
    checkOutput("midrst_idle", {31'b0, bus.busy}, 32'd0);

    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    waitResult("unsigned_neg1", 2, 3'b001);
`ifdef COMP_SIGNED_EN
    bus.sgn = 1'b1;
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    bus.sgn = 1'b0;
    waitResult("signed_neg1", 2, 3'b100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
